// File: rtl/if_pkg.sv
// Shared constants for the IF stage: bubble/reset values, RV32 opcodes,
// RVC quadrant/funct3 codes and the realignment state encoding.
package if_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [2:0] C0_LW    = 3'b010;
    localparam logic [2:0] C0_SW    = 3'b110;
    localparam logic [2:0] C1_ADDI  = 3'b000;
    localparam logic [2:0] C1_JAL   = 3'b001;
    localparam logic [2:0] C1_LI    = 3'b010;
    localparam logic [2:0] C1_ARITH = 3'b100;
    localparam logic [2:0] C1_J     = 3'b101;
    localparam logic [2:0] C1_BEQZ  = 3'b110;
    localparam logic [2:0] C1_BNEZ  = 3'b111;
    localparam logic [2:0] C2_SLLI  = 3'b000;
    localparam logic [2:0] C2_CR    = 3'b100;

    typedef enum logic [1:0] {
        ALIGNED    = 2'd0,
        HALF       = 2'd1,
        MISALIGNED = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

endpackage

// File: rtl/rvc_expander.sv
// Combinational RV32C -> RV32I expander for the subset the fetch stage supports;
// anything else (including reserved encodings) becomes the canonical NOP.
module rvc_expander
    import if_pkg::*;
(
    input  logic [15:0] c_i,
    output logic [31:0] instr_o
);

    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6_sx, mem_imm;
    logic [20:0] j_off;
    logic [12:0] b_off;

    assign rd      = c_i[11:7];
    assign rs2     = c_i[6:2];
    assign rdp     = {2'b01, c_i[4:2]};
    assign rs1p    = {2'b01, c_i[9:7]};
    assign imm6_sx = {{6{c_i[12]}}, c_i[12], c_i[6:2]};
    assign mem_imm = {5'b0, c_i[5], c_i[12:10], c_i[6], 2'b00};
    assign j_off   = {{9{c_i[12]}}, c_i[12], c_i[8], c_i[10:9], c_i[6], c_i[7], c_i[2],
                      c_i[11], c_i[5:3], 1'b0};
    assign b_off   = {{4{c_i[12]}}, c_i[12], c_i[6:5], c_i[2], c_i[11:10], c_i[4:3], 1'b0};

    always_comb begin
        instr_o = NOP_INSN;
        case (c_i[1:0])
            RVC_Q0: begin
                case (c_i[15:13])
                    C0_LW:   instr_o = enc_i(mem_imm, rs1p, 3'b010, rdp, LOAD);
                    C0_SW:   instr_o = {mem_imm[11:5], rdp, rs1p, 3'b010, mem_imm[4:0], STORE};
                    default: instr_o = NOP_INSN;
                endcase
            end
            RVC_Q1: begin
                case (c_i[15:13])
                    C1_ADDI: instr_o = enc_i(imm6_sx, rd, 3'b000, rd, OP_IMM);
                    C1_JAL:  instr_o = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd1, JAL};
                    C1_LI:   instr_o = enc_i(imm6_sx, 5'd0, 3'b000, rd, OP_IMM);
                    C1_ARITH: begin
                        case (c_i[11:10])
                            2'b00: if (!c_i[12]) instr_o = enc_r(7'b0000000, rs2, rs1p, 3'b101, rs1p, OP_IMM);
                            2'b01: if (!c_i[12]) instr_o = enc_r(7'b0100000, rs2, rs1p, 3'b101, rs1p, OP_IMM);
                            2'b10: instr_o = enc_i(imm6_sx, rs1p, 3'b111, rs1p, OP_IMM);
                            default: begin
                                // c[12]=1 here is the RV64-only subw/addw space
                                if (!c_i[12]) begin
                                    case (c_i[6:5])
                                        2'b00:   instr_o = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p, OP);
                                        2'b01:   instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p, OP);
                                        2'b10:   instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p, OP);
                                        default: instr_o = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p, OP);
                                    endcase
                                end
                            end
                        endcase
                    end
                    C1_J:    instr_o = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd0, JAL};
                    C1_BEQZ, C1_BNEZ:
                        instr_o = {b_off[12], b_off[10:5], 5'd0, rs1p, {2'b00, c_i[13]},
                                   b_off[4:1], b_off[11], BRANCH};
                    default: instr_o = NOP_INSN;
                endcase
            end
            RVC_Q2: begin
                case (c_i[15:13])
                    C2_SLLI: if (!c_i[12]) instr_o = enc_r(7'b0000000, rs2, rd, 3'b001, rd, OP_IMM);
                    C2_CR: begin
                        if (!c_i[12]) begin
                            if (rs2 == 5'd0) begin
                                if (rd != 5'd0) instr_o = enc_i(12'd0, rd, 3'b000, 5'd0, JALR);
                            end else begin
                                instr_o = enc_r(7'b0000000, rs2, 5'd0, 3'b000, rd, OP);
                            end
                        end else begin
                            if (rs2 == 5'd0) begin
                                if (rd != 5'd0) instr_o = enc_i(12'd0, rd, 3'b000, 5'd1, JALR);
                            end else begin
                                instr_o = enc_r(7'b0000000, rs2, rd, 3'b000, rd, OP);
                            end
                        end
                    end
                    default: instr_o = NOP_INSN;
                endcase
            end
            default: instr_o = NOP_INSN;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, reads instruction memory, registers instruction_1/PC_1/jj_16.
// Define RVC_EN to add the halfword realignment buffer and the RVC expander.
//
// state      | meaning
// ALIGNED    | PC_r[1]=0, no buffered halfword; fetch word PC_r[31:2]
// HALF       | halfword at PC_r is buffered (tag==PC_r); prefetch word PC_r[31:2]+1
// MISALIGNED | PC_r[1]=1 after a redirect with nothing buffered; fetch word PC_r[31:2]
module instruction_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memory_stall,
    input  logic [31:0] branch_address,
    input  logic        PC_src,
    input  logic        IF_flush,
    input  logic        PC_write,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall,
    output logic [31:0] instruction_1,
    output logic [31:0] PC_1,
    output logic        jj_16
);

    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc1_q, pc1_d;
    logic        freeze, redirect;

    assign freeze        = memory_stall | ICACHE_stall;
    assign redirect      = PC_src | IF_flush;
    assign ICACHE_ren    = rst_n;
    assign instruction_1 = instr_q;
    assign PC_1          = pc1_q;

`ifdef RVC_EN
    fetch_state_e state_q, state_d, cur_state;
    logic [15:0]  buf_q, buf_d, exp_in;
    logic [31:0]  tag_q, tag_d, exp_out;
    logic         jj_q, jj_d;
    logic         unused_ba0;

    assign unused_ba0 = branch_address[0];
    assign jj_16      = jj_q;

    // The tag compare guards against ever consuming a stale halfword
    always_comb begin
        if (state_q == HALF && tag_q == pc_q) cur_state = HALF;
        else if (pc_q[1])                     cur_state = MISALIGNED;
        else                                  cur_state = ALIGNED;
    end

    always_comb begin
        case (cur_state)
            HALF:       exp_in = buf_q;
            MISALIGNED: exp_in = ICACHE_rdata[31:16];
            default:    exp_in = ICACHE_rdata[15:0];
        endcase
    end

    assign ICACHE_addr = (cur_state == HALF) ? pc_q[31:2] + 30'd1 : pc_q[31:2];

    rvc_expander u_rvc_expander (
        .c_i     (exp_in),
        .instr_o (exp_out)
    );

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc1_d   = pc1_q;
        jj_d    = jj_q;
        state_d = state_q;
        buf_d   = buf_q;
        tag_d   = tag_q;
        if (!freeze && !PC_write) begin
            if (redirect) begin
                pc_d    = {branch_address[31:1], 1'b0};
                instr_d = NOP;
                jj_d    = 1'b0;
                state_d = ALIGNED;
            end else begin
                pc1_d = pc_q;
                case (cur_state)
                    HALF: begin
                        if (buf_q[1:0] != 2'b11) begin
                            instr_d = exp_out;
                            jj_d    = 1'b1;
                            pc_d    = pc_q + 32'd2;
                            state_d = ALIGNED;
                        end else begin
                            instr_d = {ICACHE_rdata[15:0], buf_q};
                            jj_d    = 1'b0;
                            buf_d   = ICACHE_rdata[31:16];
                            tag_d   = pc_q + 32'd4;
                            pc_d    = pc_q + 32'd4;
                        end
                    end
                    MISALIGNED: begin
                        if (ICACHE_rdata[17:16] != 2'b11) begin
                            instr_d = exp_out;
                            jj_d    = 1'b1;
                            pc_d    = pc_q + 32'd2;
                            state_d = ALIGNED;
                        end else begin
                            // upper half needs the next word: bubble now, finish from HALF
                            instr_d = NOP;
                            jj_d    = 1'b0;
                            buf_d   = ICACHE_rdata[31:16];
                            tag_d   = pc_q;
                            state_d = HALF;
                        end
                    end
                    default: begin
                        if (ICACHE_rdata[1:0] == 2'b11) begin
                            instr_d = ICACHE_rdata;
                            jj_d    = 1'b0;
                            pc_d    = pc_q + 32'd4;
                            state_d = ALIGNED;
                        end else begin
                            instr_d = exp_out;
                            jj_d    = 1'b1;
                            buf_d   = ICACHE_rdata[31:16];
                            tag_d   = pc_q + 32'd2;
                            pc_d    = pc_q + 32'd2;
                            state_d = HALF;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pc1_q   <= RESET_PC;
            jj_q    <= 1'b0;
            state_q <= ALIGNED;
            buf_q   <= 16'h0000;
            tag_q   <= 32'h0000_0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc1_q   <= pc1_d;
            jj_q    <= jj_d;
            state_q <= state_d;
            buf_q   <= buf_d;
            tag_q   <= tag_d;
        end
    end
`else
    logic [1:0] unused_ba_lo;

    assign unused_ba_lo = branch_address[1:0];
    assign jj_16        = 1'b0;
    assign ICACHE_addr  = pc_q[31:2];

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc1_d   = pc1_q;
        if (!freeze && !PC_write) begin
            if (redirect) begin
                pc_d    = {branch_address[31:2], 2'b00};
                instr_d = NOP;
            end else begin
                instr_d = ICACHE_rdata;
                pc1_d   = pc_q;
                pc_d    = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pc1_q   <= RESET_PC;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc1_q   <= pc1_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch; builds with or without RVC_EN.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          NCYC     = 3000;

    logic        clk = 1'b0;
    logic        rst_n, memory_stall, PC_src, IF_flush, PC_write, ICACHE_stall;
    logic [31:0] branch_address, ICACHE_rdata, instruction_1, PC_1;
    logic        ICACHE_ren, jj_16;
    logic [29:0] ICACHE_addr;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    assign ICACHE_rdata = ICACHE_stall ? 32'hDEAD_BEEF : mem[ICACHE_addr[7:0]];

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memory_stall   (memory_stall),
        .branch_address (branch_address),
        .PC_src         (PC_src),
        .IF_flush       (IF_flush),
        .PC_write       (PC_write),
        .ICACHE_ren     (ICACHE_ren),
        .ICACHE_addr    (ICACHE_addr),
        .ICACHE_rdata   (ICACHE_rdata),
        .ICACHE_stall   (ICACHE_stall),
        .instruction_1  (instruction_1),
        .PC_1           (PC_1),
        .jj_16          (jj_16)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc1;
        logic        jj;
        logic        chk_pc1;
        logic        ren;
        logic [29:0] addr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model: architectural PC plus "which word was last read"
    logic [31:0] m_pc, m_instr, m_pc1;
    logic        m_jj, m_chk, m_last_v;
    logic [29:0] m_last_w;
    int          starts[$];

`ifdef RVC_EN
    localparam int NTAB = 13;
    logic [15:0] c_tab [NTAB] = '{16'h0505, 16'h4505, 16'h0001, 16'h852E, 16'h952E,
                                  16'h41C8, 16'hA011, 16'h8502, 16'h8C05, 16'hC501,
                                  16'h8005, 16'h0000, 16'h2011};
    logic [31:0] x_tab [NTAB] = '{32'h0015_0513, 32'h0010_0513, 32'h0000_0013, 32'h00B0_0533,
                                  32'h00B5_0533, 32'h0045_A503, 32'h0040_006F, 32'h0005_0067,
                                  32'h4094_0433, 32'h0005_0463, 32'h0014_5413, 32'h0000_0013,
                                  32'h0040_00EF};

    function automatic logic [31:0] exp16(input logic [15:0] h);
        for (int i = 0; i < NTAB; i++)
            if (c_tab[i] == h) return x_tab[i];
        return 32'hBAD0_BAD0;
    endfunction
`endif

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic held_now();
`ifdef RVC_EN
        return m_last_v && m_pc[1] && (m_last_w == m_pc[31:2]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input logic rst, input logic frz, input logic pcw,
                              input logic redir, input logic [31:0] ba);
        logic [15:0] h;
        logic        is32, held;
        exp_t        e;
        if (!rst) begin
            m_pc = RESET_PC; m_last_v = 1'b0; m_instr = NOP; m_pc1 = RESET_PC;
            m_jj = 1'b0; m_chk = 1'b1;
        end else if (frz || pcw) begin
            // nothing moves
        end else if (redir) begin
`ifdef RVC_EN
            m_pc = {ba[31:1], 1'b0};
`else
            m_pc = {ba[31:2], 2'b00};
`endif
            m_last_v = 1'b0; m_instr = NOP; m_jj = 1'b0; m_chk = 1'b0;
        end else begin
            m_pc1 = m_pc; m_chk = 1'b1;
`ifdef RVC_EN
            held = held_now();
            h    = hw(m_pc);
            is32 = (h[1:0] == 2'b11);
            if (is32 && m_pc[1] && !held) begin
                m_instr = NOP; m_jj = 1'b0;
                m_last_w = m_pc[31:2]; m_last_v = 1'b1;
            end else begin
                if (!held) begin
                    m_last_w = m_pc[31:2]; m_last_v = 1'b1;
                end else if (is32) begin
                    m_last_w = m_pc[31:2] + 30'd1;
                end
                m_instr = is32 ? {hw(m_pc + 32'd2), h} : exp16(h);
                m_jj    = !is32;
                m_pc    = m_pc + (is32 ? 32'd4 : 32'd2);
            end
`else
            h = 16'h0; is32 = 1'b1; held = 1'b0;
            m_instr = mem[m_pc[9:2]]; m_jj = 1'b0;
            m_pc = m_pc + 32'd4;
`endif
        end
        e.instr = m_instr; e.pc1 = m_pc1; e.jj = m_jj; e.chk_pc1 = m_chk; e.ren = rst;
        e.addr  = m_pc[31:2] + {29'd0, held_now()};
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
`ifdef RVC_EN
        t = 32'(starts[$urandom_range(0, starts.size() - 1)]) | 32'($urandom_range(0, 1));
`else
        t = 32'($urandom_range(0, 1023));
`endif
        if ($urandom_range(0, 3) == 0) t = t + 32'hFFFF_FC00;
        return t;
    endfunction

    task automatic build_mem();
`ifdef RVC_EN
        logic [15:0] hws [512];
        logic [31:0] r;
        int          hi;
        hws[0] = 16'h0505; hws[1] = 16'h4505;
        starts.push_back(0); starts.push_back(2);
        hi = 2;
        while (hi < 512) begin
            starts.push_back(hi * 2);
            if (hi < 511 && $urandom_range(0, 1) == 1) begin
                r = $urandom | 32'h3;
                hws[hi] = r[15:0]; hws[hi + 1] = r[31:16];
                hi += 2;
            end else begin
                hws[hi] = c_tab[$urandom_range(0, NTAB - 1)];
                hi += 1;
            end
        end
        for (int i = 0; i < 256; i++) mem[i] = {hws[2 * i + 1], hws[2 * i]};
`else
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
`endif
    endtask

    // monitor: one expectation per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("instruction_1", instruction_1, e.instr);
                chk("jj_16", {31'd0, jj_16}, {31'd0, e.jj});
                chk("ICACHE_ren", {31'd0, ICACHE_ren}, {31'd0, e.ren});
                chk("ICACHE_addr", {2'b00, ICACHE_addr}, {2'b00, e.addr});
                if (e.chk_pc1) chk("PC_1", PC_1, e.pc1);
            end
        end
    end

    // driver
    initial begin
        logic [31:0] bubble_tgt;
        build_mem();
        bubble_tgt = 32'h0000_0102;
`ifdef RVC_EN
        foreach (starts[i])
            if (starts[i] >= 32'h100 && starts[i][1] && bubble_tgt == 32'h0000_0102)
                bubble_tgt = 32'(starts[i]);
`endif
        rst_n = 1'b0; memory_stall = 1'b0; PC_src = 1'b0; IF_flush = 1'b0;
        PC_write = 1'b0; ICACHE_stall = 1'b0; branch_address = 32'h0;
        model_step(rst_n, 1'b0, 1'b0, 1'b0, branch_address);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst_n = !(cyc < 2 || cyc == 1500);
            memory_stall = 1'b0; ICACHE_stall = 1'b0; PC_write = 1'b0; PC_src = 1'b0;
            branch_address = $urandom;
            if (cyc < 12) begin
            end else if (cyc == 12) begin
                PC_src = 1'b1; branch_address = bubble_tgt;
            end else if (cyc == 20 || cyc == 21) begin
                PC_write = 1'b1; PC_src = 1'b1; branch_address = pick_target();
            end else if (cyc == 22) begin
                PC_src = 1'b1; branch_address = pick_target();
            end else if (cyc >= 30 && cyc <= 32) begin
                ICACHE_stall = 1'b1;
            end else if (cyc == 33) begin
                memory_stall = 1'b1;
            end else if (cyc == 1500) begin
                ICACHE_stall = 1'b1;
            end else begin
                ICACHE_stall = ($urandom_range(0, 99) < 15);
                memory_stall = ($urandom_range(0, 99) < 5);
                PC_write     = ($urandom_range(0, 99) < 10);
                PC_src       = ($urandom_range(0, 99) < 8);
                if (PC_src) branch_address = pick_target();
            end
            IF_flush = PC_src;
            model_step(rst_n, memory_stall | ICACHE_stall, PC_write, PC_src | IF_flush,
                       branch_address);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the ALU pipeline. Owns the PC, reads the instruction memory and delivers instruction_1/PC_1/jj_16 to the ID stage.
- Consumes the ID stage's redirect and hazard controls: branch_address, PC_src, IF_flush, PC_write.
- With RVC enabled, realigns 16-bit instructions through a halfword buffer and expands them to 32-bit before ID sees them.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- memory_stall  in  1  data-side stall; freezes the whole stage.
- branch_address  in  32  redirect target from ID.
- PC_src  in  1  redirect request from ID.
- IF_flush  in  1  squash instruction_1 (always paired with PC_src).
- PC_write  in  1  1 = ID hazard: hold PC and instruction_1 (active-high hold).
- ICACHE_ren  out  1  instruction read request.
- ICACHE_addr  out  30  word address.
- ICACHE_rdata  in  32  read word; valid in any cycle with ICACHE_ren=1 and ICACHE_stall=0.
- ICACHE_stall  in  1  instruction memory busy.
- instruction_1  out  32  registered instruction to ID (always 32-bit form).
- PC_1  out  32  address of instruction_1.
- jj_16  out  1  instruction_1 originated as a 16-bit instruction.

Behaviour:
- Reset (rst_n=0 at posedge): PC_r=RESET_PC, instruction_1=NOP, PC_1=RESET_PC, jj_16=0, halfword buffer invalid, state=ALIGNED. ICACHE_ren is 0 during reset and 1 in every later cycle.
- Priority at each posedge: reset > freeze (memory_stall | ICACHE_stall) > hold (PC_write) > redirect (PC_src | IF_flush) > advance.
- Freeze: all registers hold; ICACHE_addr and ICACHE_ren stay stable.
- Hold: PC, buffer, instruction_1, PC_1 and jj_16 hold. PC_write beats PC_src because the branch compare is not yet valid.
- Redirect: PC_r=branch_address with bit0 forced to 0; instruction_1=NOP; jj_16=0; buffer invalidated; state=ALIGNED. No instruction fetched this cycle is issued.
- Advance: the instruction at PC_r is registered into instruction_1, with PC_1=PC_r. PC_r += 4, or += 2 when the instruction is 16-bit.
- Latency: one cycle from a valid ICACHE_rdata to instruction_1.
- States, RVC_EN defined:
  - ALIGNED (PC_r[1]=0):
    - ICACHE_addr=PC_r[31:2].
    - rdata[1:0]==2'b11: issue rdata as a 32-bit instruction.
    - Otherwise: issue expand(rdata[15:0]), jj_16=1, buffer rdata[31:16] tagged PC_r+2, go to HALF.
  - HALF (buffer valid, tag==PC_r):
    - Buffered halfword is 16-bit: issue its expansion, no memory word consumed, ICACHE_addr=PC_r[31:2]+1 (prefetch), go to ALIGNED.
    - Buffered halfword is 32-bit: ICACHE_addr=PC_r[31:2]+1; issue {rdata[15:0], buf}; buffer rdata[31:16] tagged PC_r+4; stay in HALF.
  - MISALIGNED (PC_r[1]=1, buffer invalid, entered after a redirect):
    - ICACHE_addr=PC_r[31:2].
    - rdata[17:16]!=2'b11: issue expand(rdata[31:16]), go to ALIGNED.
    - Otherwise: issue NOP (one bubble), buffer rdata[31:16] tagged PC_r, go to HALF.
- Address arithmetic is modulo 2^32; ICACHE_addr wraps from 30'h3FFF_FFFF to 0.
- Unsupported 16-bit encodings expand to NOP.
- Reset mid-stall clears state regardless of ICACHE_stall.

Optional Feature:
- Macro RVC_EN.
- Defined: realignment buffer, the three states above, rvc_expander instantiated, jj_16 live.
- Undefined:
  - No buffer and no states; ICACHE_addr=PC_r[31:2]; PC += 4 always.
  - jj_16 tied 0; branch_address[1:0] ignored.
  - Every fetched word is issued as-is.

Decomposition:
- Package if_pkg holds: NOP, RESET_PC default, opcode constants (OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR), RVC quadrant/funct3 constants, and the state encodings ALIGNED/HALF/MISALIGNED.
- Sub-module rvc_expander: combinational 16→32 expansion.
- rvc_expander supports: c.addi, c.nop, c.li, c.lw, c.sw, c.mv, c.add, c.sub, c.and, c.or, c.xor, c.andi, c.slli, c.srli, c.srai, c.j, c.jal, c.jr, c.jalr, c.beqz, c.bnez.

Test Plan:
- Reset then release, memory returns 32'h0050_0093 at word 0 → cycle after release: instruction_1=32'h0050_0093, PC_1=0, jj_16=0, ICACHE_addr=1 next.
- Word 0 = {16'h4505 (c.li a0,1), 16'h0505 (c.addi a0,1)} under RVC_EN → instruction_1=32'h0015_0513 with PC_1=0, then 32'h0010_0513 with PC_1=2 and no new word consumed; jj_16=1 for both.
- 32-bit instruction straddling words 1/2 (PC=6) → issued once as the concatenation with PC_1=6; PC_r becomes 10; buffer tagged 10.
- PC_src=1 with branch_address=32'h0000_0102 → instruction_1=NOP, then NOP bubble if word 0x40 upper half is 32-bit, then the full instruction with PC_1=0x102.
- PC_write=1 for 2 cycles with PC_src=1 simultaneously → PC_r, instruction_1 and PC_1 unchanged; redirect only when PC_write falls.
- ICACHE_stall=1 for 3 cycles mid-HALF, plus one cycle of memory_stall → all outputs and ICACHE_addr stable; sequence resumes with no duplicated or lost instruction.
